// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder sequencer.
// State encodings are fixed so waveforms read the same in every build.
package serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// One-bit full adder cell: s = a ^ b ^ c1, c2 = carry out.
// Port order (a, b, s, c1, c2) matches the existing library cell.
module full_adder (
    input  logic a,
    input  logic b,
    output logic s,
    input  logic c1,
    output logic c2
);

    assign s  = a ^ b ^ c1;
    assign c2 = (a & b) | (c1 & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder reused over WIDTH clocks, LSB first.
// start/ready handshake in, one-cycle done pulse with sum/cout out.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_a_q, shift_a_d;
    logic [WIDTH-1:0] shift_b_q, shift_b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             accept;
    logic             fa_s, fa_c2;

    assign accept = start && (state_q == ST_IDLE);

    full_adder u_fa (
        .a  (shift_a_q[0]),
        .b  (shift_b_q[0]),
        .s  (fa_s),
        .c1 (carry_q),
        .c2 (fa_c2)
    );

    // State register.
    // NOTE: flops use non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (cnt_q == LAST_BIT) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from registered state only.
    always_comb begin
        ready = (state_q == ST_IDLE);
        busy  = (state_q == ST_RUN);
        done  = (state_q == ST_DONE);
    end

    // Datapath next values: load on accept, shift one bit per RUN edge.
    always_comb begin
        cnt_d     = cnt_q;
        shift_a_d = shift_a_q;
        shift_b_d = shift_b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        if (accept) begin
            shift_a_d = op_a;
            shift_b_d = op_b;
            carry_d   = cin;
            cnt_d     = '0;
            sum_d     = '0;
            cout_d    = 1'b0;
        end else if (state_q == ST_RUN) begin
            shift_a_d = {1'b0, shift_a_q[WIDTH-1:1]};
            shift_b_d = {1'b0, shift_b_q[WIDTH-1:1]};
            sum_d     = {fa_s, sum_q[WIDTH-1:1]};
            carry_d   = fa_c2;
            cnt_d     = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) cout_d = fa_c2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            shift_a_q <= '0;
            shift_b_q <= '0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            cout_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            shift_a_q <= shift_a_d;
            shift_b_q <= shift_b_d;
            sum_q     <= sum_d;
            carry_q   <= carry_d;
            cout_q    <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): directed vector table,
// held-start, mid-run reset and random additions against a + b + cin.
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] op_a, op_b;
    logic             cin;
    logic             ready, busy, done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int n_vec  = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int exp_done = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] s;
        logic       co;
        string      nm;
    } vec_t;

    vec_t vecs[8];

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op_a  (op_a),
        .op_b  (op_b),
        .cin   (cin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic check(input logic [31:0] act, input logic [31:0] exp, input string nm);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with ready high.
    task automatic run_add(input logic [7:0] a, input logic [7:0] b, input logic c,
                           input logic [7:0] es, input logic ec, input string nm);
        int busy_cyc;
        check(ready, 1, {nm, ":ready_before"});
        op_a  = a;
        op_b  = b;
        cin   = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op_a  = 8'($urandom);
        op_b  = 8'($urandom);
        cin   = 1'($urandom);
        busy_cyc = 0;
        while (busy && busy_cyc < 40) begin
            check(done, 0, {nm, ":done_early"});
            busy_cyc++;
            @(negedge clk);
        end
        check(busy_cyc, WIDTH, {nm, ":busy_cycles"});
        check(done, 1, {nm, ":done"});
        check(sum, es, {nm, ":sum"});
        check(cout, ec, {nm, ":cout"});
        exp_done++;
        @(negedge clk);
        check(done, 0, {nm, ":done_one_cycle"});
        check(ready, 1, {nm, ":ready_after"});
        check(sum, es, {nm, ":sum_held"});
    endtask

    initial begin
        logic [8:0] gold;
        logic [7:0] ra, rb;
        logic       rc;
        int         done_at[$];
        int         dc;

        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "zero"};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ff_plus_1"};
        vecs[2] = '{8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, "3c_42"};
        vecs[3] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, "a5_5a_cin"};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "msb_carry"};
        vecs[5] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, "cin_ripple"};
        vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "all_ones"};
        vecs[7] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, "alt_bits"};

        rst_n = 1'b0;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        cin   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check(ready, 1, "rst:ready");
        check(busy, 0, "rst:busy");
        check(done, 0, "rst:done");
        check(sum, 0, "rst:sum");
        check(cout, 0, "rst:cout");
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) run_add(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s, vecs[i].co, vecs[i].nm);

        // start held high: 0x12+0x34 then 0xF0+0x0F+1, one done per WIDTH+2 cycles.
        op_a = 8'h12; op_b = 8'h34; cin = 1'b0; start = 1'b1;
        for (int j = 1; j <= 24; j++) begin
            @(negedge clk);
            if (j == 1) begin
                op_a = 8'hF0; op_b = 8'h0F; cin = 1'b1;
            end
            if (j == 11) begin
                start = 1'b0;
                op_a = 8'h00; op_b = 8'h00; cin = 1'b0;
            end
            if (done) begin
                done_at.push_back(j);
                if (done_at.size() == 1) begin
                    check(sum, 8'h46, "hold:sum1");
                    check(cout, 0, "hold:cout1");
                end else begin
                    check(sum, 8'h00, "hold:sum2");
                    check(cout, 1, "hold:cout2");
                end
            end
        end
        exp_done += 2;
        check(done_at.size(), 2, "hold:done_count");
        if (done_at.size() == 2) begin
            check(done_at[0], WIDTH + 1, "hold:done1_cycle");
            check(done_at[1], 2 * WIDTH + 3, "hold:done2_cycle");
        end
        check(ready, 1, "hold:ready_end");

        // Reset during RUN after four bits of 0xFF+0xFF.
        op_a = 8'hFF; op_b = 8'hFF; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check(busy, 1, "rst_mid:busy_before");
        check(sum, 8'hE0, "rst_mid:partial_sum");
        rst_n = 1'b0;
        #1;
        check(sum, 0, "rst_mid:sum");
        check(cout, 0, "rst_mid:cout");
        check(ready, 1, "rst_mid:ready");
        check(busy, 0, "rst_mid:busy");
        check(done, 0, "rst_mid:done");
        @(negedge clk);
        rst_n = 1'b1;
        dc = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (done) dc++;
        end
        check(dc, 0, "rst_mid:no_done");
        run_add(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, "after_rst");

        for (int i = 0; i < 256; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            gold = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            run_add(ra, rb, rc, gold[7:0], gold[8], "rand");
        end

        check(done_cnt, exp_done, "done_count_total");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
